// File: rtl/mul_div_if.sv
// Request/result bundle between the CPU and the multi-cycle multiply/divide sequencer.
interface mul_div_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  div_by_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide,
// one bit per cycle, with sign correction applied in a final fix-up cycle.
module mul_div_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ITER       = 32
) (
  input logic        clk,
  input logic        rst,
  mul_div_if.slave   bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFix} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;

  logic            signed_op;
  logic            is_div;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      sum;
  logic [W:0]      r_sh;
  logic [W:0]      diff;
  logic [2*W-1:0]  mul_next, div_next;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quot, rem;

  always_comb begin
    signed_op = ~op_q[0];
    is_div    = op_q[1];
    mag_a     = (signed_op && a_q[W-1]) ? -a_q : a_q;
    mag_b     = (signed_op && b_q[W-1]) ? -b_q : b_q;

    // Multiply: add multiplicand when Q[0] set, keep the carry, shift {carry,P,Q} right.
    sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {sum, acc_q[W-1:1]};

    // Divide: R after the left shift needs W+1 bits once the divisor exceeds 2^(W-1);
    // bit W of the difference is the borrow.
    r_sh     = acc_q[2*W-1:W-1];
    diff     = r_sh - {1'b0, mcand_q};
    div_next = diff[W] ? {r_sh[W-1:0], acc_q[W-2:0], 1'b0}
                       : {diff[W-1:0], acc_q[W-2:0], 1'b1};

    prod = quo_neg_q ? -acc_q : acc_q;
    quot = quo_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.A;
          b_d     = bus.B;
          dbz_d   = 1'b0;
          state_d = StPrep;
        end
      end
      StPrep: begin
        quo_neg_d = signed_op & (a_q[W-1] ^ b_q[W-1]);
        rem_neg_d = signed_op & a_q[W-1];
        cnt_d     = '0;
        if (is_div) begin
          acc_d   = {{W{1'b0}}, mag_a};
          mcand_d = mag_b;
        end else begin
          acc_d   = {{W{1'b0}}, mag_b};
          mcand_d = mag_a;
        end
        state_d = StCalc;
      end
      StCalc: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (!is_div) begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end else if (b_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: vector table plus hand sequences for
// ignored starts, back-to-back ops, divide-by-zero clearing and mid-op reset.
module tb_mul_div_seq;
  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[11];

  mul_div_if #(.DATA_WIDTH(32)) bus ();

  mul_div_seq #(.DATA_WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive a request for one edge; returns at the sample point just after the accepting edge.
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0BAD_F00D;
  endtask

  // Edges counted after the accepting edge until done; busy counted from the accepting edge.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = -1;
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int busy_cnt;
    int done_seen;

    vecs[0]  = '{OpMult,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{OpMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{OpMultu, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[5]  = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[7]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OpDivu,  32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{OpDivu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      do_start(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(edges, busy_cnt);
      check($sformatf("v%0d_latency", i), 32'(edges), 32'd34);
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'd34);
      check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
    end

    // Start issued in the done cycle of the divide-by-zero op; a start mid-op is ignored.
    do_start(OpMultu, 32'd3, 32'd5);
    check("dbz_cleared", 32'(bus.div_by_zero), 32'd0);
    check("done_dropped", 32'(bus.done), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      bus.start = (i == 5);
      bus.op    = OpDivu;
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
    end
    bus.start = 1'b0;
    check("ign_latency", 32'(edges), 32'd34);
    check("ign_hi", bus.hi, 32'd0);
    check("ign_lo", bus.lo, 32'd15);
    @(posedge clk);
    #1;
    check("ign_not_queued", 32'(bus.busy), 32'd0);

    do_start(OpMultu, 32'd6, 32'd7);
    wait_done(edges, busy_cnt);
    check("b2b_latency", 32'(edges), 32'd34);
    check("b2b_lo", bus.lo, 32'd42);

    // Reset during a multiply abandons it and clears the results.
    do_start(OpMult, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    do_start(OpMult, 32'hFFFF_FFF9, 32'd3);
    wait_done(edges, busy_cnt);
    check("post_rst_latency", 32'(edges), 32'd34);
    check("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
    check("post_rst_lo", bus.lo, 32'hFFFF_FFEB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
Multi-cycle integer multiply/divide sequencer beside the single-cycle ALU in the MIPS CPU. It executes MULT/MULTU/DIV/DIVU by iterating a 32-bit add/subtract datapath one bit per cycle, then applies sign correction. Results go to HI/LO registers that the CPU reads. The CPU stalls on busy and samples results on done.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported.
ITER, 32, iteration count; must equal DATA_WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
A  input  32  multiplicand / dividend; sampled with start
B  input  32  multiplier / divisor; sampled with start
busy  output  1  high while state is not IDLE
done  output  1  single-cycle pulse; hi/lo/div_by_zero valid from this cycle
hi  output  32  MULT*: product[63:32]; DIV*: remainder
lo  output  32  MULT*: product[31:0]; DIV*: quotient
div_by_zero  output  1  set with done when a DIV/DIVU had B==0; cleared at next accepted start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; iteration counter=0. This applies mid-operation: the in-flight op is abandoned and hi/lo are not updated.
- States: IDLE -> PREP (1 cycle) -> CALC (ITER cycles) -> FIX (1 cycle) -> IDLE.
- IDLE: on start=1, latch op, A, B; clear div_by_zero; go to PREP. If start=0, stay.
- PREP: for signed ops, take magnitudes |A| and |B|. Record sign_q = A[31]^B[31] and sign_r = A[31]. Unsigned ops use the raw values. Load the counter with 0.
- CALC, multiply: 64-bit accumulator {P,Q}, Q initially = multiplier. Each cycle, if Q[0] then add the multiplicand to P (33-bit sum, carry kept). Then shift {carry,P,Q} right by 1.
- CALC, divide: restoring division on 64-bit {R,Q}, Q initially = dividend. Each cycle, shift left by 1 and trial-subtract the divisor from R (33-bit). If there is no borrow, keep the difference and set Q[0]=1; otherwise restore R and set Q[0]=0.
- Counter increments each CALC cycle. Leave CALC after the cycle with counter==ITER-1.
- FIX: compute the signed results, then write hi/lo.
  - MULT: negate the 64-bit product if sign_q.
  - DIV: negate the quotient if sign_q and the remainder if sign_r.
  - Divide by zero (B==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=A as latched, div_by_zero=1. The op still takes full latency.
  - Then go to IDLE with done=1 for exactly one cycle.
- Timing, with start accepted at edge 0:
  - busy=1 in the cycles following edges 0..33.
  - hi/lo are updated at edge 34.
  - done=1 in the cycle following edge 34; busy=0 in that cycle.
  - Total latency: 35 cycles start-to-done.
- start while busy is ignored; no queueing.
- start in the same cycle that done is high is accepted, because state is IDLE. This gives back-to-back ops; done drops next cycle.
- hi/lo hold their value until the next FIX or reset. Changes on A/B/op after start are ignored.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no error flag.
- All arithmetic is modulo 2^32 per result word. No overflow output.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> done exactly 35 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 34 cycles.
- MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with same operands -> hi=0, lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100, B=7 -> lo=14, hi=2. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=100, B=0 -> after 35 cycles: lo=0xFFFFFFFF, hi=100, div_by_zero=1. Next start clears div_by_zero.
- Pulse start again at cycle 5 of a busy op with different operands -> ignored; the first result is unchanged. Assert start in the done cycle -> new op is accepted and its done arrives 35 cycles later.
- Assert rst at cycle 10 of a MULT -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows. A new start afterwards completes normally.
